// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized rx, oversampled start/data/[parity]/stop; rx_valid one clk at stop mid-bit, no backpressure.
// Optional parity bit compiled in with `define UART_RX_PARITY_EN.
module uart_rx #(
  parameter int DATA_BITS    = 8,
  parameter int OverSampling = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bclk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CW = $clog2(OverSampling);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] MID   = CW'(OverSampling / 2 - 1);
  localparam logic [CW-1:0] LAST  = CW'(OverSampling - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic ODD = (PARITY_ODD != 0);
  logic pbit;
  logic parity_err_q;
  assign parity_err = parity_err_q;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
  assign parity_err = 1'b0;
`endif

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 bclk_q;
  logic                 tick;
  logic                 armed;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bitcnt;
  logic [DATA_BITS-1:0] shreg;

  assign tick = bclk & ~bclk_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      bclk_q    <= 1'b0;
      state     <= IDLE;
      armed     <= 1'b1;
      cnt       <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbit         <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      bclk_q   <= bclk;
      rx_valid <= 1'b0;
      // A break must see the line return high before the next start is accepted.
      if (rx_s) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (!rx_s && armed) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (cnt == MID) begin
              cnt    <= '0;
              bitcnt <= '0;
              if (rx_s) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= DATA;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (cnt == LAST) begin
              cnt    <= '0;
              shreg  <= {rx_s, shreg[DATA_BITS-1:1]};
              bitcnt <= bitcnt + 1'b1;
              if (bitcnt == BLAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              pbit  <= rx_s;
              state <= STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (cnt == LAST) begin
              cnt       <= '0;
              rx_data   <= shreg;
              frame_err <= ~rx_s;
              rx_valid  <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
              if (!rx_s) armed <= 1'b0;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= (^shreg) ^ pbit ^ ODD;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame table plus glitch, break and mid-frame reset sequences.
module tb_uart_rx;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       bclk  = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, busy;

  int nvec   = 0;
  int nerr   = 0;
  int pulses = 0;
  int bdiv   = 0;
  int p0;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pbit;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  vec_t vt[7];

  uart_rx #(.DATA_BITS(8), .OverSampling(16), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .bclk(bclk), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Baud generator: one bclk rising edge every 4 clks.
  always @(negedge clk) begin
    bdiv = (bdiv == 3) ? 0 : bdiv + 1;
    bclk = (bdiv == 0);
  end

  always @(negedge clk) begin
    if (rx_valid === 1'b1) pulses = pulses + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) @(posedge bclk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
`ifdef UART_RX_PARITY_EN
    rx = pbit;
    wait_ticks(16);
`endif
    rx = stop;
    wait_ticks(16);
  endtask

  initial begin
    //        data   stop  pbit gap  exp_data fe    pe
    vt[0] = '{8'hA5, 1'b1, 1'b0, 0,  8'hA5, 1'b0, 1'b0};
    vt[1] = '{8'h3C, 1'b0, 1'b0, 16, 8'h3C, 1'b1, 1'b0};
    vt[2] = '{8'h01, 1'b1, 1'b1, 0,  8'h01, 1'b0, 1'b0};
    vt[3] = '{8'h00, 1'b1, 1'b0, 0,  8'h00, 1'b0, 1'b0};
    vt[4] = '{8'hFF, 1'b1, 1'b0, 0,  8'hFF, 1'b0, 1'b0};
    vt[5] = '{8'h07, 1'b1, 1'b0, 0,  8'h07, 1'b0, 1'b1};
    vt[6] = '{8'h07, 1'b1, 1'b1, 16, 8'h07, 1'b0, 1'b0};

    reset = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset rx_data", rx_data, 0);
    chk("reset rx_valid", rx_valid, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset parity_err", parity_err, 0);
    chk("reset busy", busy, 0);
    reset = 1'b1;
    wait_ticks(4);

    // Table frames; entries without a gap run back-to-back.
    for (int i = 0; i < 7; i++) begin
      p0 = pulses;
      send_frame(vt[i].data, vt[i].stop, vt[i].pbit);
      chk($sformatf("v%0d pulses", i), pulses - p0, 1);
      chk($sformatf("v%0d rx_data", i), rx_data, vt[i].exp_data);
      chk($sformatf("v%0d frame_err", i), frame_err, vt[i].exp_fe);
      chk($sformatf("v%0d parity_err", i), parity_err, PAR_EN ? vt[i].exp_pe : 1'b0);
      chk($sformatf("v%0d busy", i), busy, 0);
      if (vt[i].gap > 0) begin
        rx = 1'b1;
        wait_ticks(vt[i].gap);
      end
    end

    // Short low pulse: start bit rejected at mid-bit.
    p0 = pulses;
    rx = 1'b0;
    wait_ticks(2);
    chk("glitch busy high", busy, 1);
    wait_ticks(2);
    rx = 1'b1;
    wait_ticks(6);
    chk("glitch busy low", busy, 0);
    chk("glitch pulses", pulses - p0, 0);
    chk("glitch rx_data held", rx_data, 8'h07);

    // Break: exactly one framing-error frame, no retrigger while low.
    p0 = pulses;
    rx = 1'b0;
    wait_ticks(300);
    chk("break pulses", pulses - p0, 1);
    chk("break frame_err", frame_err, 1);
    chk("break rx_data", rx_data, 8'h00);
    chk("break busy", busy, 0);
    rx = 1'b1;
    wait_ticks(16);
    p0 = pulses;
    send_frame(8'h5A, 1'b1, 1'b0);
    chk("post-break pulses", pulses - p0, 1);
    chk("post-break rx_data", rx_data, 8'h5A);
    chk("post-break frame_err", frame_err, 0);

    // Reset after four data bits of 0x55.
    rx = 1'b1;
    wait_ticks(16);
    p0 = pulses;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx = (i % 2 == 0);
      wait_ticks(16);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("midreset rx_data", rx_data, 0);
    chk("midreset rx_valid", rx_valid, 0);
    chk("midreset frame_err", frame_err, 0);
    chk("midreset parity_err", parity_err, 0);
    chk("midreset busy", busy, 0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    wait_ticks(16);
    chk("midreset pulses", pulses - p0, 0);
    p0 = pulses;
    send_frame(8'h81, 1'b1, 1'b0);
    chk("post-reset pulses", pulses - p0, 1);
    chk("post-reset rx_data", rx_data, 8'h81);
    chk("post-reset frame_err", frame_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
